cci_mpf_prim_heap_dualfree: RTL and testbench
=============================================

// Module: cci_mpf_prim_heap_dualfree
//
// PURPOSE
// - Tag allocator and payload store on the request side of a reorder path.
// - Allocates one tag per cycle and stores a payload per tag.
// - Tags are released out of order on two independent response channels.
// - Each channel can read back a tag's payload when its response arrives.
// - Pairs with cci_mpf_prim_scoreboard_dualport: the heap frees out of order,
//   the scoreboard retires in order.
//
// PARAMETERS
// - N_ENTRIES       32  number of tags; power of 2, >= 4
// - N_DATA_BITS     64  payload width stored per tag
// - MIN_FREE_SLOTS  1   notFull drops when free tags <= this value
//
// PORTS
// - clk          in   1            clock
// - reset_n      in   1            asynchronous, active-low reset
// - enq_en       in   1            allocate tag allocIdx and store enqData
// - enqData      in   N_DATA_BITS  payload written at allocIdx
// - notFull      out  1            allocation permitted
// - allocIdx     out  clog2(N)     tag granted by the next enq_en
// - readReq[0:1] in   1            read payload of readIdx[i]
// - readIdx[0:1] in   clog2(N)     tag to read
// - readRdy[0:1] out  1            readData[i] valid
// - readData[0:1] out N_DATA_BITS  payload of the tag requested last cycle
// - free[0:1]    in   1            release tag freeIdx[i]
// - freeIdx[0:1] in   clog2(N)     tag to release
//
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - freeVec = all ones; free_cnt = N_ENTRIES; allocIdx = 0;
//     notFull = 0; readRdy = 0. Payload RAM is not reset.
//   - notFull rises on the first clk edge after reset_n deasserts.
// - State:
//   - freeVec[N]: 1 = tag is free.
//   - free_cnt: clog2(N)+1 bits, equal to popcount(freeVec).
// - Next-state, each cycle:
//   - fv_nxt = (freeVec & ~(enq_en << allocIdx)) | (free[0] << freeIdx[0])
//     | (free[1] << freeIdx[1]).
//   - free_cnt_nxt = free_cnt - enq_en + free[0] + free[1]; no wrap at
//     0 or N.
// - allocIdx is registered as the lowest set bit of fv_nxt.
//   - It therefore always names the lowest free tag.
//   - A freed tag can be re-granted on the next cycle.
// - notFull is registered as (free_cnt_nxt > MIN_FREE_SLOTS).
// - enq_en writes enqData to the payload at allocIdx in the same cycle.
// - Reads have a 1-cycle latency:
//   - readRdy[i] <= readReq[i];
//   - readData[i] <= payload[readIdx[i]].
//   - The ports are independent; both may read the same tag in one cycle.
// - Free and read of the same tag in one cycle is legal; the read returns
//   the stored payload.
// - Fatal assertions:
//   - enq_en while !notFull;
//   - free of a tag that is already free;
//   - free[0] && free[1] with equal freeIdx;
//   - readReq on a free tag;
//   - readReq on the tag being allocated this cycle;
//   - N_ENTRIES not a power of 2.
// - Full boundary: with free_cnt == MIN_FREE_SLOTS+1, an enq_en without any
//   free drops notFull next cycle. Simultaneous enq_en + free keeps it high.
// - Empty-of-allocations boundary: two frees raising free_cnt to N_ENTRIES
//   are legal. free_cnt never exceeds N_ENTRIES.
// - Reset mid-operation: all outstanding tags are discarded. The block
//   restarts from the reset state; frees arriving before notFull rises are
//   illegal.
//
// STRUCTURE
// - Shared package cci_mpf_prim_heap_pkg holds:
//   - t_HEAP_IDX = logic [$clog2(N_ENTRIES)-1:0];
//   - t_HEAP_CNT = logic [$clog2(N_ENTRIES):0].
// - Sub-module cci_mpf_prim_heap_dualfree_alloc holds freeVec, free_cnt,
//   the fv_nxt logic, the priority encoder and the allocIdx/notFull
//   registers.
// - Payload storage is two 1-write/1-read arrays, one per read port. Both
//   arrays share the enq write.
//
// TESTING
// - Reset, then 32 back-to-back enq_en with no frees:
//   - allocIdx = 0,1,...,31;
//   - notFull falls after the 31st enq (free_cnt = 1);
//   - the 32nd enq fires the assertion.
// - Allocate tags 0-7 with payload = 0xA0+tag, then read tag 5 on port 0
//   and tag 2 on port 1 in one cycle:
//   - next cycle readRdy = {1,1};
//   - readData[0] = 0xA5, readData[1] = 0xA2.
// - Allocate 0-3, then free[0] = tag 2 and free[1] = tag 0 in one cycle:
//   - next allocIdx = 0; after that enq, allocIdx = 2; after that, 4.
// - Hold free_cnt = 2 with MIN_FREE_SLOTS = 1; apply enq_en + free[1]
//   (tag 9) in one cycle:
//   - notFull stays 1; free_cnt stays 2.
// - Assert reset_n low mid-burst (10 tags outstanding, readReq active):
//   - readRdy = 0 and notFull = 0 immediately;
//   - after release, allocIdx = 0 and free_cnt = 32.
// - Free tag 3 twice, and free both ports with freeIdx = 6:
//   - each case triggers the corresponding fatal assertion.

Source files
------------

// File: rtl/cci_mpf_prim_heap_pkg.sv
// cci_mpf_prim_heap_pkg: default sizing and shared index/count types for the dual-free heap
package cci_mpf_prim_heap_pkg;
   localparam int HEAP_N_ENTRIES = 32;
   localparam int HEAP_N_DATA_BITS = 64;
   localparam int HEAP_MIN_FREE_SLOTS = 1;
   typedef logic [$clog2(HEAP_N_ENTRIES)-1:0] t_HEAP_IDX;
   typedef logic [$clog2(HEAP_N_ENTRIES):0] t_HEAP_CNT;
endpackage

// File: rtl/cci_mpf_prim_heap_dualfree_alloc.sv
// cci_mpf_prim_heap_dualfree_alloc: free-tag vector, free count, lowest-free-tag grant and notFull
module cci_mpf_prim_heap_dualfree_alloc
   import cci_mpf_prim_heap_pkg::*;
#(
   parameter int N_ENTRIES = HEAP_N_ENTRIES,
   parameter int MIN_FREE_SLOTS = HEAP_MIN_FREE_SLOTS
)(
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         enq_en,
   input  logic                         free [2],
   input  logic [$clog2(N_ENTRIES)-1:0] freeIdx [2],
   output logic                         notFull,
   output logic [$clog2(N_ENTRIES)-1:0] allocIdx,
   output logic [N_ENTRIES-1:0]         freeVec
);
   localparam int IW = $clog2(N_ENTRIES);
   localparam int CW = IW + 1;
   logic [N_ENTRIES-1:0] fv_nxt;
   logic [CW-1:0] free_cnt, cnt_nxt;
   logic [IW-1:0] low;
   always_comb begin
      fv_nxt = freeVec;
      if (enq_en) fv_nxt[allocIdx] = 1'b0;
      for (int i = 0; i < 2; i++) if (free[i]) fv_nxt[freeIdx[i]] = 1'b1;
      cnt_nxt = free_cnt - CW'(enq_en) + CW'(free[0]) + CW'(free[1]);
      low = '0;
      for (int i = N_ENTRIES - 1; i >= 0; i--) if (fv_nxt[i]) low = IW'(i);
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         freeVec <= '1;
         free_cnt <= CW'(N_ENTRIES);
         allocIdx <= '0;
         notFull <= 1'b0;
      end else begin
         freeVec <= fv_nxt;
         free_cnt <= cnt_nxt;
         allocIdx <= low;
         notFull <= cnt_nxt > CW'(MIN_FREE_SLOTS);
      end
   end
   a_pow2: assert property (@(posedge clk) ((N_ENTRIES & (N_ENTRIES - 1)) == 0) && (N_ENTRIES >= 4))
      else $fatal(1, "N_ENTRIES must be a power of 2 and at least 4");
   a_enq_full: assert property (@(posedge clk) disable iff (!reset_n) enq_en |-> notFull)
      else $fatal(1, "enq_en while notFull is low");
   a_free_same: assert property (@(posedge clk) disable iff (!reset_n)
      !(free[0] && free[1] && freeIdx[0] == freeIdx[1]))
      else $fatal(1, "both free ports release the same tag");
   for (genvar i = 0; i < 2; i++) begin : g_free_chk
      a_double_free: assert property (@(posedge clk) disable iff (!reset_n)
         free[i] |-> !freeVec[freeIdx[i]])
         else $fatal(1, "free of a tag that is already free");
   end
endmodule

// File: rtl/cci_mpf_prim_heap_dualfree.sv
// cci_mpf_prim_heap_dualfree: tag allocator with per-tag payload, two out-of-order free/read channels
module cci_mpf_prim_heap_dualfree
   import cci_mpf_prim_heap_pkg::*;
#(
   parameter int N_ENTRIES = HEAP_N_ENTRIES,
   parameter int N_DATA_BITS = HEAP_N_DATA_BITS,
   parameter int MIN_FREE_SLOTS = HEAP_MIN_FREE_SLOTS
)(
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         enq_en,
   input  logic [N_DATA_BITS-1:0]       enqData,
   output logic                         notFull,
   output logic [$clog2(N_ENTRIES)-1:0] allocIdx,
   input  logic                         readReq [2],
   input  logic [$clog2(N_ENTRIES)-1:0] readIdx [2],
   output logic                         readRdy [2],
   output logic [N_DATA_BITS-1:0]       readData [2],
   input  logic                         free [2],
   input  logic [$clog2(N_ENTRIES)-1:0] freeIdx [2]
);
   logic [N_ENTRIES-1:0] freeVec;
   logic [N_DATA_BITS-1:0] mem [2][N_ENTRIES];
   cci_mpf_prim_heap_dualfree_alloc #(
      .N_ENTRIES(N_ENTRIES),
      .MIN_FREE_SLOTS(MIN_FREE_SLOTS)
   ) alloc (
      .clk(clk),
      .reset_n(reset_n),
      .enq_en(enq_en),
      .free(free),
      .freeIdx(freeIdx),
      .notFull(notFull),
      .allocIdx(allocIdx),
      .freeVec(freeVec)
   );
   // One copy of the payload per read port keeps each array at 1 write / 1 read.
   always_ff @(posedge clk) begin
      for (int p = 0; p < 2; p++) begin
         if (enq_en) mem[p][allocIdx] <= enqData;
         readData[p] <= mem[p][readIdx[p]];
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         readRdy[0] <= 1'b0;
         readRdy[1] <= 1'b0;
      end else begin
         readRdy[0] <= readReq[0];
         readRdy[1] <= readReq[1];
      end
   end
   for (genvar i = 0; i < 2; i++) begin : g_read_chk
      a_read_free: assert property (@(posedge clk) disable iff (!reset_n)
         readReq[i] |-> !freeVec[readIdx[i]])
         else $fatal(1, "read of a free tag");
      a_read_alloc: assert property (@(posedge clk) disable iff (!reset_n)
         !(readReq[i] && enq_en && readIdx[i] == allocIdx))
         else $fatal(1, "read of the tag being allocated");
   end
endmodule

// File: tb/tb_cci_mpf_prim_heap_dualfree.sv
// tb_cci_mpf_prim_heap_dualfree: directed boundary cases plus random traffic against a set-based model
module tb_cci_mpf_prim_heap_dualfree;
   import cci_mpf_prim_heap_pkg::*;
   logic clk = 1'b0;
   logic reset_n = 1'b1;
   logic enq_en = 1'b0;
   logic [63:0] enqData = '0;
   logic notFull;
   t_HEAP_IDX allocIdx;
   logic readReq [2] = '{1'b0, 1'b0};
   t_HEAP_IDX readIdx [2] = '{5'd0, 5'd0};
   logic readRdy [2];
   logic [63:0] readData [2];
   logic free [2] = '{1'b0, 1'b0};
   t_HEAP_IDX freeIdx [2] = '{5'd0, 5'd0};
   int n_cmp = 0;
   int n_bad = 0;

   cci_mpf_prim_heap_dualfree #(.N_ENTRIES(32), .N_DATA_BITS(64), .MIN_FREE_SLOTS(1)) dut (
      .clk(clk), .reset_n(reset_n), .enq_en(enq_en), .enqData(enqData),
      .notFull(notFull), .allocIdx(allocIdx), .readReq(readReq), .readIdx(readIdx),
      .readRdy(readRdy), .readData(readData), .free(free), .freeIdx(freeIdx)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: a tag is either busy (allocated) or free; grant the lowest free tag.
   bit busy [32];
   logic [63:0] pm [32];
   int m_alloc = 0;
   bit m_nf = 0;
   bit m_rdy [2] = '{0, 0};
   logic [63:0] m_data [2];
   int nfree;
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         foreach (busy[i]) busy[i] = 0;
         m_alloc = 0;
         m_nf = 0;
         m_rdy = '{0, 0};
      end else begin
         for (int p = 0; p < 2; p++) begin
            m_rdy[p] = readReq[p];
            if (readReq[p]) m_data[p] = pm[readIdx[p]];
         end
         if (enq_en) begin
            pm[m_alloc] = enqData;
            busy[m_alloc] = 1;
         end
         for (int p = 0; p < 2; p++) if (free[p]) busy[freeIdx[p]] = 0;
         nfree = 0;
         m_alloc = -1;
         for (int i = 0; i < 32; i++) if (!busy[i]) begin
            nfree++;
            if (m_alloc < 0) m_alloc = i;
         end
         if (m_alloc < 0) m_alloc = 0;
         m_nf = nfree > 1;
      end
   end

   always @(posedge clk) begin
      #1;
      check("allocIdx", 64'(allocIdx), 64'(m_alloc));
      check("notFull", 64'(notFull), 64'(m_nf));
      for (int p = 0; p < 2; p++) begin
         check($sformatf("readRdy%0d", p), 64'(readRdy[p]), 64'(m_rdy[p]));
         if (m_rdy[p]) check($sformatf("readData%0d", p), readData[p], m_data[p]);
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic idle();
      enq_en = 0;
      readReq = '{1'b0, 1'b0};
      free = '{1'b0, 1'b0};
   endtask

   task automatic do_reset();
      idle();
      reset_n = 0;
      tick();
      tick();
      check("rst_allocIdx", 64'(allocIdx), 64'd0);
      check("rst_notFull", 64'(notFull), 64'd0);
      check("rst_readRdy0", 64'(readRdy[0]), 64'd0);
      check("rst_readRdy1", 64'(readRdy[1]), 64'd0);
      reset_n = 1;
      tick();
      check("post_rst_notFull", 64'(notFull), 64'd1);
      check("post_rst_allocIdx", 64'(allocIdx), 64'd0);
   endtask

   task automatic enq(input logic [63:0] d);
      enq_en = 1;
      enqData = d;
      tick();
      enq_en = 0;
   endtask

   int q [$];
   int j;

   initial begin
      #1;
      do_reset();
      // 31 back-to-back allocations: lowest tags in order, notFull falls at one free tag
      for (int i = 0; i < 31; i++) begin
         check("burst_allocIdx", 64'(allocIdx), 64'(i));
         check("burst_notFull", 64'(notFull), 64'd1);
         enq_en = 1;
         enqData = 64'(i);
         tick();
      end
      enq_en = 0;
      check("burst_full_notFull", 64'(notFull), 64'd0);
      check("burst_last_allocIdx", 64'(allocIdx), 64'd31);

      do_reset();
      for (int t = 0; t < 8; t++) enq(64'h0A0 + 64'(t));
      readReq = '{1'b1, 1'b1};
      readIdx = '{5'd5, 5'd2};
      tick();
      readReq = '{1'b0, 1'b0};
      check("rd_rdy0", 64'(readRdy[0]), 64'd1);
      check("rd_rdy1", 64'(readRdy[1]), 64'd1);
      check("rd_data0", readData[0], 64'hA5);
      check("rd_data1", readData[1], 64'hA2);

      do_reset();
      for (int t = 0; t < 4; t++) enq(64'h100 + 64'(t));
      free = '{1'b1, 1'b1};
      freeIdx = '{5'd2, 5'd0};
      tick();
      free = '{1'b0, 1'b0};
      check("ooo_alloc0", 64'(allocIdx), 64'd0);
      enq(64'h200);
      check("ooo_alloc2", 64'(allocIdx), 64'd2);
      enq(64'h202);
      check("ooo_alloc4", 64'(allocIdx), 64'd4);

      do_reset();
      for (int t = 0; t < 30; t++) enq(64'h300 + 64'(t));
      check("edge_notFull_two", 64'(notFull), 64'd1);
      check("edge_alloc30", 64'(allocIdx), 64'd30);
      enq_en = 1;
      enqData = 64'h330;
      free[1] = 1;
      freeIdx[1] = 5'd9;
      tick();
      idle();
      check("edge_enq_free_notFull", 64'(notFull), 64'd1);
      check("edge_regrant9", 64'(allocIdx), 64'd9);
      enq(64'h309);
      check("edge_full_notFull", 64'(notFull), 64'd0);

      do_reset();
      for (int t = 0; t < 10; t++) enq(64'h400 + 64'(t));
      readReq = '{1'b1, 1'b1};
      readIdx = '{5'd3, 5'd7};
      tick();
      check("mid_rdy_before", 64'(readRdy[0] & readRdy[1]), 64'd1);
      reset_n = 0;
      #1;
      check("mid_rst_readRdy0", 64'(readRdy[0]), 64'd0);
      check("mid_rst_readRdy1", 64'(readRdy[1]), 64'd0);
      check("mid_rst_notFull", 64'(notFull), 64'd0);
      idle();
      tick();
      reset_n = 1;
      tick();
      check("mid_post_allocIdx", 64'(allocIdx), 64'd0);
      check("mid_post_notFull", 64'(notFull), 64'd1);

      for (int c = 0; c < 3000; c++) begin
         idle();
         q.delete();
         foreach (busy[i]) if (busy[i]) q.push_back(i);
         enq_en = m_nf && ($urandom_range(0, 99) < 55);
         enqData = {$urandom, $urandom};
         if (q.size() > 0 && $urandom_range(0, 2) == 0) begin
            free[0] = 1;
            freeIdx[0] = 5'(q[$urandom_range(0, q.size() - 1)]);
         end
         if (q.size() > 1 && $urandom_range(0, 2) == 0) begin
            do j = $urandom_range(0, q.size() - 1);
            while (free[0] && 5'(q[j]) == freeIdx[0]);
            free[1] = 1;
            freeIdx[1] = 5'(q[j]);
         end
         for (int p = 0; p < 2; p++) if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
            readReq[p] = 1;
            readIdx[p] = 5'(q[$urandom_range(0, q.size() - 1)]);
         end
         tick();
      end
      idle();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
